// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port integer register file.
package regfile_pkg;

    localparam int   XLEN_DEFAULT = 64;
    localparam logic WR_SRC_ALU   = 1'b0;
    localparam logic WR_SRC_MEM   = 1'b1;
    localparam int   ZERO_REG     = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: decode read port, writeback port and load-issue port.
interface regfile_mp_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            rd_en;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rd_valid;
    logic            rs1_pending;
    logic            rs2_pending;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            wr_src;
    logic [XLEN-1:0] wr_alu_data;
    logic [XLEN-1:0] wr_mem_data;
    logic            ld_issue;
    logic [AW-1:0]   ld_addr;

    modport master (
        output rd_en, rs1_addr, rs2_addr,
        output wr_en, wr_addr, wr_src, wr_alu_data, wr_mem_data,
        output ld_issue, ld_addr,
        input  rs1_data, rs2_data, rd_valid, rs1_pending, rs2_pending
    );

    modport slave (
        input  rd_en, rs1_addr, rs2_addr,
        input  wr_en, wr_addr, wr_src, wr_alu_data, wr_mem_data,
        input  ld_issue, ld_addr,
        output rs1_data, rs2_data, rd_valid, rs1_pending, rs2_pending
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue,
// cleared on memory writeback. A set on the same edge as a clear wins,
// since it represents a newer load. Register 0 never goes pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] lk1_addr,
    input  logic [AW-1:0] lk2_addr,
    output logic          lk1_pend,
    output logic          lk2_pend
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Next pending vector: clear first, then set, so set has priority.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) pend_d[clr_addr] = 1'b0;
        if (set_en) pend_d[set_addr] = 1'b1;
        pend_d[ZERO_REG] = 1'b0;
    end

    // Pending vector register; reset drops any outstanding loads.
    always_ff @(posedge clk) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign lk1_pend = pend_q[lk1_addr];
    assign lk2_pend = pend_q[lk2_addr];

endmodule

// File: rtl/regfile_mp.sv
// Two-read / one-write integer register file with writeback select and
// pending-load scoreboard for load-use hazard detection.
// Optional macro REGFILE_BYPASS_EN: a read sampled on the same edge as a
// write to the same nonzero register returns the new data and the
// post-writeback pending bit. Without it the pre-write values are returned
// and decode is expected to stall one cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    regfile_mp_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] wr_data;
    logic            wr_hit;
    logic            clr_en;
    logic            sb_pend1;
    logic            sb_pend2;
    logic [XLEN-1:0] rd1_val;
    logic [XLEN-1:0] rd2_val;
    logic            pend1_val;
    logic            pend2_val;

    assign wr_data = (bus.wr_src == WR_SRC_MEM) ? bus.wr_mem_data : bus.wr_alu_data;
    assign wr_hit  = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));
    assign clr_en  = bus.wr_en && (bus.wr_src == WR_SRC_MEM);

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (bus.ld_issue),
        .set_addr (bus.ld_addr),
        .clr_en   (clr_en),
        .clr_addr (bus.wr_addr),
        .lk1_addr (bus.rs1_addr),
        .lk2_addr (bus.rs2_addr),
        .lk1_pend (sb_pend1),
        .lk2_pend (sb_pend2)
    );

    // Values captured by the read ports, with optional same-edge forwarding.
    always_comb begin
        rd1_val   = (bus.rs1_addr == AW'(ZERO_REG)) ? '0 : regs[bus.rs1_addr];
        rd2_val   = (bus.rs2_addr == AW'(ZERO_REG)) ? '0 : regs[bus.rs2_addr];
        pend1_val = sb_pend1;
        pend2_val = sb_pend2;
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && bus.wr_addr == bus.rs1_addr) rd1_val = wr_data;
        if (wr_hit && bus.wr_addr == bus.rs2_addr) rd2_val = wr_data;
        // A same-edge load issue to the register re-arms it, so no forwarded clear.
        if (clr_en && bus.wr_addr == bus.rs1_addr &&
            !(bus.ld_issue && bus.ld_addr == bus.rs1_addr)) pend1_val = 1'b0;
        if (clr_en && bus.wr_addr == bus.rs2_addr &&
            !(bus.ld_issue && bus.ld_addr == bus.rs2_addr)) pend2_val = 1'b0;
`endif
    end

    // Storage array; register 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[bus.wr_addr] <= wr_data;
        end
    end

    // Read-port registers: capture on rd_en, otherwise hold data and pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rs1_data    <= '0;
            bus.rs2_data    <= '0;
            bus.rd_valid    <= 1'b0;
            bus.rs1_pending <= 1'b0;
            bus.rs2_pending <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rs1_data    <= rd1_val;
                bus.rs2_data    <= rd2_val;
                bus.rs1_pending <= pend1_val;
                bus.rs2_pending <= pend2_val;
            end
        end
    end

endmodule
